fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_next.sv | 46 ++++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the instruction-fetch slice.
//   PCSRC_*          : next-PC select codes driven by decode
//   fetch_state_t    : fetch FSM state encoding (FETCH / HOLD / DRAIN)
//   DEFAULT_RESET_PC : default first fetch address after reset
package mips_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_JR  = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next.sv
// pc_next -- combinational next-PC computation for the fetch stage.
// Ports:
//   pc_f         in  32  current fetch address
//   pcsrc_d      in  2   target select from decode (seq/branch/jump/jr)
//   pcplus4_d    in  32  PC+4 of the instruction held in IF/ID
//   branch_off_d in  32  sign-extended, pre-shifted branch offset
//   jidx_d       in  26  jump instruction index
//   jr_target_d  in  32  register jump target
//   pc_plus4_f   out 32  pc_f + 4 (wraps modulo 2^32)
//   target       out 32  redirect target selected by pcsrc_d
module pc_next
    import mips_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [1:0]  pcsrc_d,
    input  logic [31:0] pcplus4_d,
    input  logic [31:0] branch_off_d,
    input  logic [25:0] jidx_d,
    input  logic [31:0] jr_target_d,
    output logic [31:0] pc_plus4_f,
    output logic [31:0] target
);

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;

    // Carries out of bit 31 are dropped, so 0xFFFF_FFFC + 4 wraps to 0.
    assign pc_plus4_f    = pc_f + 32'd4;
    assign branch_target = pcplus4_d + branch_off_d;
    assign jump_target   = {pcplus4_d[31:28], jidx_d, 2'b00};
    // Low bits are always forced to a word boundary; any misalignment
    // report is handled by the fetch stage.
    assign jr_target     = jr_target_d & 32'hFFFF_FFFC;

    always_comb begin
        target = pc_plus4_f;
        case (pcsrc_d)
            PCSRC_BR: target = branch_target;
            PCSRC_J:  target = jump_target;
            PCSRC_JR: target = jr_target;
            default:  target = pc_plus4_f;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch FSM plus IF/ID pipeline register.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (adds sticky misalign_err
// output flagging jr redirects whose target low bits are non-zero).
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   stall_d, flush_d         decode back-pressure and IF/ID squash
//   pcsrc_d, branch_off_d,
//   jidx_d, jr_target_d      redirect request from decode
//   imem_req/imem_addr       instruction memory request (addr held until ack)
//   imem_ack/imem_rdata      instruction memory response
//   instr_d/pcplus4_d/valid_d IF/ID register outputs
//   misalign_err             (macro only) sticky jr misalignment flag
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic [1:0]  pcsrc_d,
    input  logic [31:0] branch_off_d,
    input  logic [25:0] jidx_d,
    input  logic [31:0] jr_target_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic        misalign_err,
`endif
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    fetch_state_t state_reg;
    logic [31:0]  pc_f_reg;
    logic [31:0]  instr_reg;
    logic [31:0]  pcplus4_reg;
    logic         valid_reg;
    logic [31:0]  skid_reg;
    logic [31:0]  drain_target_reg;

    logic [31:0]  pc_plus4_f;
    logic [31:0]  target;
    logic         redirect;

    pc_next u_pc_next (
        .pc_f         (pc_f_reg),
        .pcsrc_d      (pcsrc_d),
        .pcplus4_d    (pcplus4_reg),
        .branch_off_d (branch_off_d),
        .jidx_d       (jidx_d),
        .jr_target_d  (jr_target_d),
        .pc_plus4_f   (pc_plus4_f),
        .target       (target)
    );

    // A redirect only counts when decode really consumes the valid
    // instruction that carries it.
    assign redirect = valid_reg & ~stall_d & (pcsrc_d != PCSRC_SEQ);

    // The request address is the PC register itself, so it cannot move
    // while a request is outstanding (DRAIN keeps the old pc_f and parks
    // the new target separately).
    assign imem_req  = (state_reg != ST_HOLD);
    assign imem_addr = pc_f_reg;
    assign instr_d   = instr_reg;
    assign pcplus4_d = pcplus4_reg;
    assign valid_d   = valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_FETCH;
            pc_f_reg         <= RESET_PC;
            instr_reg        <= 32'd0;
            pcplus4_reg      <= 32'd0;
            valid_reg        <= 1'b0;
            skid_reg         <= 32'd0;
            drain_target_reg <= 32'd0;
        end else begin
            case (state_reg)
                ST_FETCH: begin
                    if (redirect) begin
                        valid_reg <= 1'b0;
                        if (imem_ack) begin
                            pc_f_reg <= target;
                        end else begin
                            // Outstanding request must complete first.
                            drain_target_reg <= target;
                            state_reg        <= ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (!stall_d) begin
                            instr_reg   <= imem_rdata;
                            pcplus4_reg <= pc_plus4_f;
                            valid_reg   <= ~flush_d;
                            pc_f_reg    <= pc_plus4_f;
                        end else begin
                            // Park the word so it is not lost while decode stalls.
                            skid_reg  <= imem_rdata;
                            state_reg <= ST_HOLD;
                            if (flush_d) valid_reg <= 1'b0;
                        end
                    end else if (!stall_d || flush_d) begin
                        valid_reg <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (redirect) begin
                        pc_f_reg  <= target;
                        valid_reg <= 1'b0;
                        state_reg <= ST_FETCH;
                    end else if (!stall_d) begin
                        instr_reg   <= skid_reg;
                        pcplus4_reg <= pc_plus4_f;
                        valid_reg   <= ~flush_d;
                        pc_f_reg    <= pc_plus4_f;
                        state_reg   <= ST_FETCH;
                    end else if (flush_d) begin
                        valid_reg <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    valid_reg <= 1'b0;
                    if (imem_ack) begin
                        // Returned word belongs to the abandoned path.
                        pc_f_reg  <= drain_target_reg;
                        state_reg <= ST_FETCH;
                    end
                end

                default: begin
                    state_reg <= ST_FETCH;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else if (redirect && (pcsrc_d == PCSRC_JR) && (jr_target_d[1:0] != 2'b00)) begin
            misalign_reg <= 1'b1;
        end
    end

    assign misalign_err = misalign_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage -- directed self-checking bench for fetch_stage.
// Memory model: imem_rdata = 0xC000_0000 ^ imem_addr, ack driven per step.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_d;
    logic        flush_d;
    logic [1:0]  pcsrc_d;
    logic [31:0] branch_off_d;
    logic [25:0] jidx_d;
    logic [31:0] jr_target_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hC000_0000 ^ imem_addr;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pcsrc_d      (pcsrc_d),
        .branch_off_d (branch_off_d),
        .jidx_d       (jidx_d),
        .jr_target_d  (jr_target_d),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
`ifdef FETCH_MISALIGN_CHK_EN
        .misalign_err (misalign_err),
`endif
        .instr_d      (instr_d),
        .pcplus4_d    (pcplus4_d),
        .valid_d      (valid_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; pcsrc_d = 2'b00;
        branch_off_d = 32'd0; jidx_d = 26'd0; jr_target_d = 32'd0; imem_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_req",   {31'd0, imem_req}, 32'd1);
        chk("rst_valid", {31'd0, valid_d}, 32'd0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc4",   pcplus4_d, 32'h0);
        $display("txn reset addr=%08h req=%0b valid=%0b", imem_addr, imem_req, valid_d);

        // Sequential fetch
        imem_ack = 1'b1;
        tick();
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_pc4",  pcplus4_d, 32'h4);
        chk("seq1_valid", {31'd0, valid_d}, 32'd1);
        chk("seq1_instr", instr_d, 32'hC000_0000);
        $display("txn seq addr=%08h pc4=%08h instr=%08h", imem_addr, pcplus4_d, instr_d);
        tick();
        chk("seq2_addr", imem_addr, 32'h8);
        chk("seq2_pc4",  pcplus4_d, 32'h8);
        $display("txn seq addr=%08h pc4=%08h instr=%08h", imem_addr, pcplus4_d, instr_d);
        tick();
        chk("seq3_addr", imem_addr, 32'hC);
        chk("seq3_pc4",  pcplus4_d, 32'hC);
        tick();
        chk("seq4_pc4",  pcplus4_d, 32'h10);

        // Branch: 0x10 + 0xFFFF_FFF0 -> 0
        pcsrc_d = 2'b01; branch_off_d = 32'hFFFF_FFF0;
        tick();
        pcsrc_d = 2'b00;
        chk("br_addr",  imem_addr, 32'h0);
        chk("br_bubble", {31'd0, valid_d}, 32'd0);
        $display("txn branch addr=%08h valid=%0b", imem_addr, valid_d);
        tick();
        chk("br_next_instr", instr_d, 32'hC000_0000);
        chk("br_next_valid", {31'd0, valid_d}, 32'd1);

        // jr to 0x4000_0004, then jump using its pcplus4 0x4000_0008
        pcsrc_d = 2'b11; jr_target_d = 32'h4000_0004;
        tick();
        pcsrc_d = 2'b00;
        chk("jr_addr", imem_addr, 32'h4000_0004);
        tick();
        chk("jr_pc4", pcplus4_d, 32'h4000_0008);
        pcsrc_d = 2'b10; jidx_d = 26'h0000_100;
        tick();
        pcsrc_d = 2'b00;
        chk("j_addr", imem_addr, 32'h4000_0400);
        chk("j_bubble", {31'd0, valid_d}, 32'd0);
        $display("txn jump addr=%08h", imem_addr);

        // Stall with ack: skid buffer and HOLD
        tick();
        chk("pre_stall_instr", instr_d, 32'h8000_0400);
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req",   {31'd0, imem_req}, 32'd0);
            chk("hold_instr", instr_d, 32'h8000_0400);
            chk("hold_pc4",   pcplus4_d, 32'h4000_0404);
            $display("txn stall cycle=%0d req=%0b instr=%08h", i, imem_req, instr_d);
        end
        stall_d = 1'b0;
        tick();
        chk("unstall_instr", instr_d, 32'h8000_0404);
        chk("unstall_pc4",   pcplus4_d, 32'h4000_0408);
        chk("unstall_addr",  imem_addr, 32'h4000_0408);
        chk("unstall_req",   {31'd0, imem_req}, 32'd1);

        // Redirect while ack is low: DRAIN
        imem_ack = 1'b0; pcsrc_d = 2'b11; jr_target_d = 32'h0000_0200;
        tick();
        pcsrc_d = 2'b00;
        chk("drain1_addr",  imem_addr, 32'h4000_0408);
        chk("drain1_req",   {31'd0, imem_req}, 32'd1);
        chk("drain1_valid", {31'd0, valid_d}, 32'd0);
        tick();
        chk("drain2_addr",  imem_addr, 32'h4000_0408);
        chk("drain2_valid", {31'd0, valid_d}, 32'd0);
        imem_ack = 1'b1;
        tick();
        chk("drain_done_addr",  imem_addr, 32'h0000_0200);
        chk("drain_done_valid", {31'd0, valid_d}, 32'd0);
        $display("txn drain addr=%08h valid=%0b", imem_addr, valid_d);
        tick();
        chk("post_drain_instr", instr_d, 32'hC000_0200);
        chk("post_drain_pc4",   pcplus4_d, 32'h0000_0204);

        // Flush: valid cleared, PC still advances
        flush_d = 1'b1;
        tick();
        flush_d = 1'b0;
        chk("flush_valid", {31'd0, valid_d}, 32'd0);
        chk("flush_addr",  imem_addr, 32'h0000_0208);
        $display("txn flush addr=%08h valid=%0b", imem_addr, valid_d);

        // Bubble on missing ack
        tick();
        chk("refill_valid", {31'd0, valid_d}, 32'd1);
        imem_ack = 1'b0;
        tick();
        chk("bubble_valid", {31'd0, valid_d}, 32'd0);
        chk("bubble_addr",  imem_addr, 32'h0000_020C);
        imem_ack = 1'b1;
        tick();
        chk("bubble_refill_pc4", pcplus4_d, 32'h0000_0210);

        // PC wrap from 0xFFFF_FFFC
        pcsrc_d = 2'b11; jr_target_d = 32'hFFFF_FFFC;
        tick();
        pcsrc_d = 2'b00;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        chk("wrap_pc4",   pcplus4_d, 32'h0000_0000);
        $display("txn wrap addr=%08h pc4=%08h", imem_addr, pcplus4_d);

        // Misaligned jr: low bits forced to 00
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_clear", {31'd0, misalign_err}, 32'd0);
`endif
        pcsrc_d = 2'b11; jr_target_d = 32'h0000_0102;
        tick();
        pcsrc_d = 2'b00;
        chk("mis_addr", imem_addr, 32'h0000_0100);
        tick(); tick();
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
`endif
        $display("txn jr_misaligned addr=%08h", imem_addr);

        // Reset mid-handshake
        imem_ack = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_addr",  imem_addr, 32'h0);
        chk("rst2_valid", {31'd0, valid_d}, 32'd0);
        chk("rst2_instr", instr_d, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst2_mis", {31'd0, misalign_err}, 32'd0);
`endif
        imem_ack = 1'b1;
        tick();
        chk("rst2_fetch_instr", instr_d, 32'hC000_0000);
        chk("rst2_fetch_pc4",   pcplus4_d, 32'h4);
        $display("txn reset_mid addr=%08h instr=%08h", imem_addr, instr_d);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
